keypad_scan_rx: RTL



---
 rtl/keypad_scan_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan_rx.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-entry key holding register.
// Optional held-key autorepeat is compiled in with `define KEYPAD_AUTOREPEAT_EN.
//
// state    | meaning
// SCAN     | stepping the column strobe, waiting for any row to read low
// DEBOUNCE | column frozen, counting consecutive low samples of the captured row
// HELD     | key accepted, waiting for the captured row to go high
// RELEASE  | counting consecutive high samples before scanning resumes
module keypad_scan_rx #(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 64
) (
   input  logic       slow_clk,
   input  logic       Reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

   state_t     state, state_nxt;
   logic [1:0] col_idx, col_idx_nxt;
   logic [1:0] row_idx, row_idx_nxt;
   logic [1:0] row_pri;
   logic [3:0] cnt, cnt_nxt;
   logic       emit;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [7:0] RP_N = 8'(REPEAT_SCANS);
   logic [7:0] rep_cnt, rep_cnt_nxt;
`endif

   // lowest-numbered low row wins when several keys share the column
   always_comb begin
      row_pri = 2'd0;
      if (!row_in[0])      row_pri = 2'd0;
      else if (!row_in[1]) row_pri = 2'd1;
      else if (!row_in[2]) row_pri = 2'd2;
      else if (!row_in[3]) row_pri = 2'd3;
   end

   always_comb begin
      state_nxt   = state;
      col_idx_nxt = col_idx;
      row_idx_nxt = row_idx;
      cnt_nxt     = cnt;
      emit        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_nxt = rep_cnt;
`endif
      case (state)
         SCAN: begin
            if (row_in == 4'hF) begin
               col_idx_nxt = col_idx + 2'd1;
            end else begin
               row_idx_nxt = row_pri;
               cnt_nxt     = 4'd1;
               state_nxt   = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!row_in[row_idx]) begin
               cnt_nxt = cnt + 4'd1;
               if (cnt + 4'd1 == DB_N) begin
                  emit      = 1'b1;
                  state_nxt = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_cnt_nxt = 8'd0;
`endif
               end
            end else begin
               col_idx_nxt = col_idx + 2'd1;
               state_nxt   = SCAN;
            end
         end
         HELD: begin
            if (row_in[row_idx]) begin
               cnt_nxt   = 4'd1;
               state_nxt = RELEASE;
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (rep_cnt + 8'd1 == RP_N) begin
                  emit        = 1'b1;
                  rep_cnt_nxt = 8'd0;
               end else begin
                  rep_cnt_nxt = rep_cnt + 8'd1;
               end
`endif
            end
         end
         RELEASE: begin
            // a low sample here is release bounce: back to HELD without re-emitting
            if (row_in[row_idx]) begin
               cnt_nxt = cnt + 4'd1;
               if (cnt + 4'd1 == DB_N) begin
                  col_idx_nxt = col_idx + 2'd1;
                  state_nxt   = SCAN;
               end
            end else begin
               state_nxt = HELD;
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge slow_clk or posedge Reset) begin
      if (Reset) begin
         state   <= SCAN;
         col_idx <= 2'd0;
         col_out <= 4'b1110;
         row_idx <= 2'd0;
         cnt     <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt <= 8'd0;
`endif
      end else begin
         state   <= state_nxt;
         col_idx <= col_idx_nxt;
         col_out <= ~(4'b0001 << col_idx_nxt);
         row_idx <= row_idx_nxt;
         cnt     <= cnt_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt <= rep_cnt_nxt;
`endif
      end
   end

   always_ff @(posedge slow_clk or posedge Reset) begin
      if (Reset) begin
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         overflow  <= 1'b0;
      end else if (emit) begin
         if (!key_valid || key_ready) begin
            key_code  <= {row_idx, col_idx};
            key_valid <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (key_valid && key_ready) begin
         key_valid <= 1'b0;
      end
   end

endmodule
